// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate-field extender followed by a 2-entry skid buffer.
// The result is computed at input acceptance. It is held in a small FIFO with
// ready/valid handshakes on both sides. in_ready is registered, so it has no
// combinational path from out_ready.
// Optional feature macro: IMM_EXT_JUMP_EN adds the pc_hi port and enables
// JUMP mode (4). When the macro is undefined, mode 4 is treated as reserved.
module imm_ext_pipe #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_imm,
  input  logic [2:0]         in_mode,
`ifdef IMM_EXT_JUMP_EN
  input  logic [OUT_W-IN_W-3:0] pc_hi,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_err,
  output logic [1:0]         occupancy
);

  localparam logic [2:0] MODE_ZERO   = 3'd0;
  localparam logic [2:0] MODE_SIGN   = 3'd1;
  localparam logic [2:0] MODE_BRANCH = 3'd2;
  localparam logic [2:0] MODE_LUI    = 3'd3;
  localparam logic [2:0] MODE_JUMP   = 3'd4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   data0_q, data0_d;
  logic               err0_q, err0_d;
  logic [OUT_W-1:0]   data1_q, data1_d;
  logic               err1_q, err1_d;
  logic               in_ready_q, in_ready_d;

  logic [OUT_W-1:0]   sext;
  logic [OUT_W-1:0]   ext_data;
  logic               ext_err;
  logic               push;
  logic               pop;

  // Sign extension works for any legal IN_W/OUT_W pair, including equal widths.
  assign sext = OUT_W'(signed'(in_imm));

  // Extend the raw immediate according to the requested mode.
  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_mode)
      MODE_ZERO:   ext_data = OUT_W'(in_imm);
      MODE_SIGN:   ext_data = sext;
      MODE_BRANCH: ext_data = sext << 2;
      MODE_LUI:    ext_data = OUT_W'(in_imm[15:0]) << (OUT_W - 16);
`ifdef IMM_EXT_JUMP_EN
      MODE_JUMP:   ext_data = {pc_hi, in_imm, 2'b00};
`else
      MODE_JUMP: begin
        ext_data = '0;
        ext_err  = 1'b1;
      end
`endif
      default: begin
        ext_data = '0;
        ext_err  = 1'b1;
      end
    endcase
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = data0_q;
  assign out_err   = err0_q;
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  // Report how many results are currently held.
  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_EMPTY: occupancy = 2'd0;
      ST_ONE:   occupancy = 2'd1;
      ST_FULL:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  // Compute the next buffer state and contents. Slot 0 always holds the oldest result.
  always_comb begin
    state_d = state_q;
    data0_d = data0_q;
    err0_d  = err0_q;
    data1_d = data1_q;
    err1_d  = err1_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          data0_d = ext_data;
          err0_d  = ext_err;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          data0_d = ext_data;
          err0_d  = ext_err;
        end else if (push) begin
          state_d = ST_FULL;
          data1_d = ext_data;
          err1_d  = ext_err;
        end else if (pop) begin
          state_d = ST_EMPTY;
          data0_d = '0;
          err0_d  = 1'b0;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          data0_d = data1_q;
          err0_d  = err1_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_FULL);
  end

  // Register the buffer state. Reset discards every held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      data0_q    <= '0;
      err0_q     <= 1'b0;
      data1_q    <= '0;
      err1_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data0_q    <= data0_d;
      err0_q     <= err0_d;
      data1_q    <= data1_d;
      err1_q     <= err1_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 26, width of the raw immediate field (legal range 16..OUT_W).
REQ-002 SHALL have parameter OUT_W, default 32, width of the extended result (legal range IN_W..64).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream presents an immediate.
REQ-006 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-007 SHALL have port in_imm  input  IN_W  raw immediate field.
REQ-008 SHALL have port in_mode  input  3  extension mode (see REQ-014).
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_data  output  OUT_W  extended result.
REQ-012 SHALL have port out_err  output  1  result came from an unsupported mode.
REQ-013 SHALL have port occupancy  output  2  number of held results (0..2).

Function
REQ-014 Modes SHALL be: 0 ZERO = zero-extend; 1 SIGN = replicate in_imm[IN_W-1]; 2 BRANCH = SIGN result shifted left 2, truncated to OUT_W; 3 LUI = in_imm[15:0] placed at out[OUT_W-1:OUT_W-16], lower bits zero; 4 JUMP (see REQ-027); 5..7 reserved.
REQ-015 Reserved modes SHALL produce out_data = 0 with out_err = 1; valid modes SHALL give out_err = 0.
REQ-016 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer where out_valid and out_ready are both 1.
REQ-017 Result of an accepted input SHALL be computed at acceptance and stored; out_valid SHALL rise the cycle after acceptance (latency 1) when the buffer was empty.
REQ-018 Storage SHALL be a 2-entry skid buffer with states EMPTY, ONE, FULL; occupancy SHALL equal 0, 1, 2 respectively.
REQ-019 Transitions: EMPTY->ONE on input; ONE->FULL on input without output; ONE->EMPTY on output without input; ONE stays ONE on simultaneous input and output; FULL->ONE on output.
REQ-020 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in FULL; it SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL be 1 in ONE and FULL; out_data/out_err SHALL present the oldest entry and remain stable while out_valid=1 and out_ready=0.
REQ-022 Results SHALL leave in acceptance order; no result SHALL be dropped or duplicated.
REQ-023 Sustained in_valid=1, out_ready=1 SHALL yield one result per cycle.
REQ-024 in_imm/in_mode SHALL be ignored when no input transfer occurs.

Reset
REQ-025 With reset=1 on a rising edge: state EMPTY, occupancy=0, out_valid=0, in_ready=1, out_data=0, out_err=0; any held results SHALL be discarded, including mid-stall.
REQ-026 An input presented in the same cycle as reset SHALL NOT be accepted.

Configuration
REQ-027 Macro IMM_EXT_JUMP_EN defined: port pc_hi  input  OUT_W-IN_W-2  is present and mode 4 SHALL give {pc_hi, in_imm, 2'b00} with out_err=0; macro undefined: no pc_hi port and mode 4 SHALL behave as reserved (out_data=0, out_err=1).

Verification
REQ-028 Defaults, mode 1, in_imm=26'h2000000, out_ready=1 -> one cycle later out_valid=1, out_data=32'hFE000000, out_err=0.
REQ-029 Mode 2, in_imm=26'h3FFFFFF -> out_data=32'hFFFFFFFC; mode 0 same imm -> 32'h03FFFFFF; mode 3, in_imm=26'h0001234 -> 32'h12340000.
REQ-030 out_ready=0, three back-to-back inputs -> first two accepted, in_ready=0 from third cycle, occupancy=2; release out_ready -> results drain in order, out_data stable while stalled.
REQ-031 Mode 6 -> out_data=0, out_err=1; mode 4 with IMM_EXT_JUMP_EN, pc_hi=4'hA, in_imm=26'h0000010 -> 32'hA0000040; without macro -> 0, out_err=1.
REQ-032 Reset asserted with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, no result ever emitted for the pending inputs.
